// File: rtl/au_div_ctrl.sv
// Unsigned 8-bit divider sequencer: repeated subtraction on the shared AU.
// Owns the AU only while busy; results are latched on entry to DONE.
module au_div_ctrl #(
  parameter logic [7:0] ZERO_Q = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_zero,
  output logic       au_en,
  output logic [3:0] ac,
  output logic [7:0] au_a,
  output logic [7:0] au_b,
  input  logic [7:0] au_t,
  input  logic       au_gf
);

  typedef enum logic [1:0] {IDLE, SUB, ADDQ, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] rem_r, dvs_r, quo_r;
  logic       take;

  // R >= D: either strictly greater, or the difference is exactly zero
  assign take = au_gf | (au_t == '0);
  assign busy = (state == SUB) || (state == ADDQ);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    au_en      = 1'b0;
    ac         = '0;
    au_a       = '0;
    au_b       = '0;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (divisor == '0) ? DONE : SUB;
        else       state_next = IDLE;
      end
      SUB: begin
        au_en      = 1'b1;
        ac         = 4'b1001;
        au_a       = dvs_r;
        au_b       = rem_r;
        state_next = take ? ADDQ : DONE;
      end
      ADDQ: begin
        au_en      = 1'b1;
        ac         = 4'b1000;
        au_a       = quo_r;
        au_b       = 8'd1;
        state_next = SUB;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem_r     <= '0;
      dvs_r     <= '0;
      quo_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem_r <= dividend;
            dvs_r <= divisor;
            quo_r <= '0;
            // divide-by-zero goes straight to DONE, so latch results now
            if (divisor == '0) begin
              quotient  <= ZERO_Q;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        SUB: begin
          if (take) begin
            rem_r <= au_t;
          end else begin
            quotient  <= quo_r;
            remainder <= rem_r;
            div_zero  <= 1'b0;
          end
        end
        ADDQ: quo_r <= au_t;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_au_div_ctrl.sv
// Self-checking bench for au_div_ctrl with a behavioural AU and a
// reference model based on plain integer division.
module tb_au_div_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_zero, au_en, au_gf;
  logic [7:0] quotient, remainder, au_a, au_b, au_t;
  logic [3:0] ac;
  logic [7:0] junk;
  logic       junk_gf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  au_div_ctrl #(.ZERO_Q(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .au_en(au_en), .ac(ac), .au_a(au_a), .au_b(au_b),
    .au_t(au_t), .au_gf(au_gf)
  );

  always #5 clk = ~clk;

  // Garbage on the AU result whenever the AU is not being driven
  always @(negedge clk) begin
    junk    <= 8'($urandom);
    junk_gf <= 1'($urandom);
  end

  always_comb begin
    au_t  = junk;
    au_gf = junk_gf;
    if (au_en) begin
      case (ac)
        4'b1001: begin au_t = au_b - au_a; au_gf = (au_b > au_a); end
        4'b1000: begin au_t = au_a + au_b; au_gf = 1'b0; end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves time at the negedge of the done cycle
  // (chain=1) or of the following idle cycle (chain=0).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input bit pulse, input bit chain);
    int unsigned lat, prof_bad, hold_bad;
    logic [7:0]  eq, er, pq, pr;
    logic        ez, pz;
    bit          seen;
    if (b == 0) begin
      lat = 1; eq = 8'hFF; er = a; ez = 1'b1;
    end else begin
      lat = 2 * (a / b) + 2; eq = a / b; er = a % b; ez = 1'b0;
    end
    pq = quotient; pr = remainder; pz = div_zero;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    seen = 0; prof_bad = 0; hold_bad = 0;
    for (int unsigned k = 1; k <= 600 && !seen; k++) begin
      if (k > 1) begin
        @(negedge clk);
        start = 1'b0;
      end
      if (busy !== (k < lat) || au_en !== (k < lat)) prof_bad++;
      if (k < lat && (quotient !== pq || remainder !== pr || div_zero !== pz)) hold_bad++;
      if (k == 1 && b != 0) begin
        check("sub_ac", 32'(ac), 32'(4'b1001));
        check("sub_au_a", 32'(au_a), 32'(b));
        check("sub_au_b", 32'(au_b), 32'(a));
      end
      if (pulse && k == 3 && lat > 4) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end
      if (done) begin
        seen = 1;
        check("done_cycle", k, lat);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_zero", 32'(div_zero), 32'(ez));
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    check("busy_profile", prof_bad, 0);
    check("result_hold", hold_bad, 0);
    if (!chain) begin
      @(negedge clk);
      check("done_pulse", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_quo"}, 32'(quotient), 0);
    check({tag, "_rem"}, 32'(remainder), 0);
    check({tag, "_dz"}, 32'(div_zero), 0);
    check({tag, "_au"}, {au_en, ac, au_a, au_b}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_div(8'd7, 8'd2, 0, 0);
    run_div(8'd6, 8'd6, 0, 0);
    run_div(8'd3, 8'd5, 0, 0);
    run_div(8'd5, 8'd0, 0, 0);
    run_div(8'd255, 8'd1, 1, 0);

    // Reset asserted in cycle 10 of 200/7
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    run_div(8'd9, 8'd3, 0, 0);

    // Back-to-back starts accepted in the DONE cycle
    run_div(8'd20, 8'd6, 0, 1);
    run_div(8'd9, 8'd3, 0, 1);
    run_div(8'd4, 8'd0, 0, 1);
    run_div(8'd8, 8'd0, 0, 1);
    run_div(8'd0, 8'd7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
      run_div(a, b, 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/au_div_ctrl.md
Name: au_div_ctrl

Overview:
- Sequencer that performs 8-bit unsigned division by repeated subtraction on the shared arithmetic unit.
- Drives the AU enable, op code and operand buses, and samples the AU result and greater flag.
- Sits between the microprogram controller (start/done handshake) and the AU; it owns the AU only while busy.

Parameters:
- ZERO_Q, 8'hFF, quotient value reported on divide-by-zero.

Ports:
- clk        input   1  system clock, all state changes on rising edge
- rst        input   1  synchronous reset, active-high
- start      input   1  request a division; sampled when the block is not busy
- dividend   input   8  unsigned dividend, captured on accepted start
- divisor    input   8  unsigned divisor, captured on accepted start
- busy       output  1  high while the division is in progress
- done       output  1  one-cycle pulse when results are valid
- quotient   output  8  result quotient, held until next completion
- remainder  output  8  result remainder, held until next completion
- div_zero   output  1  set with done when divisor was 0; held with results
- au_en      output  1  AU enable
- ac         output  4  AU op code
- au_a       output  8  AU operand a
- au_b       output  8  AU operand b
- au_t       input   8  AU result, combinational from au_a/au_b/ac
- au_gf      input   1  AU greater flag (au_b > au_a on subtract)

Behaviour:
- Internal registers: R (running remainder), D (divisor), Q (running quotient).
- States: IDLE, SUB, ADDQ, DONE.
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0, au_en=0, ac=4'b0000, au_a=0, au_b=0; R, D and Q cleared. Reset mid-operation aborts immediately with the same values.
- AU drive is decoded from state:
  - IDLE/DONE: au_en=0, ac=0000, au_a=0, au_b=0.
  - SUB: au_en=1, ac=4'b1001, au_a=D, au_b=R.
  - ADDQ: au_en=1, ac=4'b1000, au_a=Q, au_b=8'd1.
- au_t is sampled only in SUB/ADDQ; it is undriven otherwise.
- IDLE or DONE with start=1 (cycle 0):
  - Capture R=dividend, D=divisor, Q=0.
  - If divisor==0: next state DONE with div_zero pending. Otherwise next state SUB.
- start while in SUB/ADDQ is ignored and not queued.
- SUB:
  - Take condition = au_gf OR (au_t==0), i.e. R >= D.
  - If take: R<=au_t, next ADDQ. Otherwise next DONE.
- ADDQ: Q<=au_t, next SUB.
- DONE entry latches the outputs:
  - Normal: quotient=Q, remainder=R, div_zero=0.
  - Divide-by-zero: quotient=ZERO_Q, remainder=dividend, div_zero=1.
  - done=1 for exactly the DONE cycle, then state IDLE unless start is accepted in that same cycle.
- busy=1 exactly in SUB and ADDQ.
- Latency from the start-sample edge, with q the final quotient:
  - Cycles 1..2q are SUB/ADDQ pairs; cycle 2q+1 is the failing SUB; done is high in cycle 2q+2.
  - Divide-by-zero: done is high in cycle 1.
- Width rules: all arithmetic is 8-bit, performed by the AU. Q cannot overflow because divisor>=1 and dividend<=255. Maximum latency is 512 cycles (255/1).
- quotient, remainder and div_zero change only on DONE entry or reset.

Test Plan:
- 7/2: start 1 cycle -> SUB shows ac=1001, au_a=2, au_b=7; done in cycle 8, quotient=3, remainder=1, div_zero=0; busy high cycles 1..7.
- 6/6: exercises the equality path (au_gf=0, au_t=0) -> done in cycle 4, quotient=1, remainder=0.
- 3/5: dividend < divisor -> one SUB, done in cycle 2, quotient=0, remainder=3.
- 5/0 -> done in cycle 1, quotient=8'hFF, remainder=5, div_zero=1; au_en stays 0 throughout.
- 255/1 -> done in cycle 512, quotient=255, remainder=0. A second start pulsed during busy with 9/3 is ignored.
- Start 200/7, assert rst in cycle 10 -> next cycle all outputs 0, state IDLE. A new start 9/3 then gives done in cycle 8, quotient=3, remainder=0. Also check back-to-back: a start asserted in the DONE cycle is accepted.
